// File: rtl/vid_pkg.sv
// Shared definitions for the video controller's mcb_clk-side blocks.
// Holds line geometry, the MCB read opcode, the fetch FSM states and the burst address helper.
package vid_pkg;

  localparam int         LINE_BYTES = 1024;
  localparam int         BUFF_DEPTH = 64;
  localparam logic [2:0] MCB_CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  // Byte address of burst n; the sum wraps within the 24-bit line address space.
  function automatic logic [23:0] burst_addr(input logic [23:0] base,
                                             input logic [2:0]  n,
                                             input logic [23:0] stride);
    burst_addr = base + (24'(n) * stride);
  endfunction

endpackage

// File: rtl/vid_line_fetch_if.sv
// MCB command/read port plus scanline buffer write port of the line fetch engine.
// master = fetch engine, slave = MCB and scanline buffer side.
interface vid_line_fetch_if;

  logic         cmd_en;
  logic [2:0]   cmd_instr;
  logic [5:0]   cmd_bl;
  logic [29:0]  cmd_byte_addr;
  logic         cmd_full;
  logic         rd_en;
  logic [31:0]  rd_data;
  logic         rd_empty;
  logic [127:0] buff_data;
  logic [5:0]   buff_addr;
  logic         buff_wr;

  modport master (
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, rd_en,
    output buff_data, buff_addr, buff_wr,
    input  cmd_full, rd_data, rd_empty
  );

  modport slave (
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, rd_en,
    input  buff_data, buff_addr, buff_wr,
    output cmd_full, rd_data, rd_empty
  );

endinterface

// File: rtl/vid_sync2.sv
// Two-flop level synchroniser for single-bit (or independent multi-bit) level crossings
// between pclk and mcb_clk.
module vid_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/vid_line_fetch.sv
// Scanline fetch engine: one request fetches a 1024-byte line as BURSTS MCB reads and packs
// 4 words per 128b buffer write. Optional read-timeout abort under `VFETCH_TIMEOUT_EN.
module vid_line_fetch
  import vid_pkg::*;
#(
  parameter int BURST_WORDS = 64,
  parameter int BURSTS      = 4
`ifdef VFETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT     = 1023
`endif
) (
  input  logic             mcb_clk,
  input  logic             reset,
  input  logic             mcb_rd,
  input  logic [19:0]      mcb_raddr,
  output logic             mcb_busy,
  output logic             fetch_err,
  vid_line_fetch_if.master bus
);

  localparam logic [2:0]  BURSTS_C = 3'(BURSTS);
  localparam logic [8:0]  TOTAL_C  = 9'(BURST_WORDS * BURSTS);
  localparam logic [23:0] STRIDE_C = 24'(BURST_WORDS * 4);

  fetch_state_e state_q, state_d;
  logic         rd_sync;
  logic         rd_prev_q;
  logic         req;
  logic [23:0]  base_q, base_d;
  logic [2:0]   issued_q, issued_d;
  logic [8:0]   words_q, words_d;
  logic [95:0]  pack_q, pack_d;
  logic         busy_q, busy_d;
  logic         buff_wr_q, buff_wr_d;
  logic [5:0]   buff_addr_q, buff_addr_d;
  logic [127:0] buff_data_q, buff_data_d;
  logic         cmd_en_c;
  logic         rd_en_c;
  logic         word_vld;
  logic [31:0]  word_c;
  logic         fill_active;

  vid_sync2 #(.WIDTH(1)) u_rd_sync (
    .clk (mcb_clk),
    .rst (reset),
    .d   (mcb_rd),
    .q   (rd_sync)
  );

  // Only the rising edge counts, so a level left high never retriggers a line.
  assign req = rd_sync & ~rd_prev_q;

  always_ff @(posedge mcb_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_prev_q   <= 1'b0;
      base_q      <= '0;
      issued_q    <= '0;
      words_q     <= '0;
      pack_q      <= '0;
      busy_q      <= 1'b0;
      buff_wr_q   <= 1'b0;
      buff_addr_q <= '0;
      buff_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_prev_q   <= rd_sync;
      base_q      <= base_d;
      issued_q    <= issued_d;
      words_q     <= words_d;
      pack_q      <= pack_d;
      busy_q      <= busy_d;
      buff_wr_q   <= buff_wr_d;
      buff_addr_q <= buff_addr_d;
      buff_data_q <= buff_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issued_d    = issued_q;
    words_d     = words_q;
    pack_d      = pack_q;
    busy_d      = busy_q;
    buff_wr_d   = 1'b0;
    buff_addr_d = buff_addr_q;
    buff_data_d = buff_data_q;
    cmd_en_c    = 1'b0;
    rd_en_c     = 1'b0;
    word_vld    = 1'b0;
    word_c      = fill_active ? 32'h0 : bus.rd_data;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d  = ST_RUN;
          base_d   = {mcb_raddr, 4'b0000};
          issued_d = '0;
          words_d  = '0;
          busy_d   = 1'b1;
        end
      end

      ST_RUN: begin
        // Commands are independent of data progress and may run ahead of it.
        if (!bus.cmd_full && (issued_q < BURSTS_C)) begin
          cmd_en_c = 1'b1;
          issued_d = issued_q + 3'd1;
        end
        if (words_q < TOTAL_C) begin
          rd_en_c  = !fill_active && !bus.rd_empty;
          word_vld = rd_en_c || fill_active;
        end
        if (word_vld) begin
          words_d = words_q + 9'd1;
          unique case (words_q[1:0])
            2'd0:    pack_d[31:0]  = word_c;
            2'd1:    pack_d[63:32] = word_c;
            2'd2:    pack_d[95:64] = word_c;
            default: begin
              buff_wr_d   = 1'b1;
              buff_addr_d = words_q[7:2];
              buff_data_d = {word_c, pack_q};
            end
          endcase
          if (words_q == (TOTAL_C - 9'd1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // The final buffer write is on the bus this cycle; busy drops right after it.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef VFETCH_TIMEOUT_EN
  localparam int            TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            fill_q, fill_d;
  logic            err_q, err_d;

  always_ff @(posedge mcb_clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
      fill_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      fill_q   <= fill_d;
      err_q    <= err_d;
    end
  end

  // Once the read FIFO has been idle for TIMEOUT cycles the rest of the line is zero-filled.
  always_comb begin
    to_cnt_d = to_cnt_q;
    fill_d   = fill_q;
    err_d    = err_q;
    if ((state_q == ST_IDLE) && req) begin
      to_cnt_d = '0;
      fill_d   = 1'b0;
    end else if ((state_q == ST_RUN) && !fill_q) begin
      if (rd_en_c) begin
        to_cnt_d = '0;
      end else if (bus.rd_empty) begin
        if (to_cnt_q == TO_LAST) begin
          fill_d = 1'b1;
          err_d  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
    end
  end

  assign fill_active = fill_q;
  assign fetch_err   = err_q;
`else
  assign fill_active = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  assign mcb_busy          = busy_q;
  assign bus.cmd_en        = cmd_en_c;
  assign bus.cmd_instr     = MCB_CMD_RD;
  assign bus.cmd_bl        = 6'(BURST_WORDS - 1);
  assign bus.cmd_byte_addr = {6'b0, burst_addr(base_q, issued_q, STRIDE_C)};
  assign bus.rd_en         = rd_en_c;
  assign bus.buff_wr       = buff_wr_q;
  assign bus.buff_addr     = buff_addr_q;
  assign bus.buff_data     = buff_data_q;

endmodule

// File: tb/tb_vid_line_fetch.sv
// Scoreboard bench for vid_line_fetch: an MCB/read-FIFO model feeds word indices, expected
// commands and buffer writes are queued at request time and popped as the DUT produces them.
module tb_vid_line_fetch;
  import vid_pkg::*;

  typedef struct {
    logic [5:0]   addr;
    logic [127:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mcb_rd;
  logic [19:0] mcb_raddr;
  logic        mcb_busy;
  logic        fetch_err;

  vid_line_fetch_if bus ();

  vid_line_fetch dut (
    .mcb_clk   (clk),
    .reset     (reset),
    .mcb_rd    (mcb_rd),
    .mcb_raddr (mcb_raddr),
    .mcb_busy  (mcb_busy),
    .fetch_err (fetch_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] exp_cmd_q[$];
  wr_t         exp_wr_q[$];
  logic [31:0] rdq[$];
  int          next_word  = 0;
  int          data_limit = 256;
  bit          stall      = 1'b0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // MCB + scanline buffer model: observe at negedge, apply pops/pushes just after posedge.
  initial begin
    bit   last_wr_seen = 1'b0;
    bit   pop;
    bit   cmd;
    wr_t  e;
    bus.cmd_full = 1'b0;
    bus.rd_empty = 1'b1;
    bus.rd_data  = 32'h0;
    forever begin
      @(negedge clk);
      pop = 1'b0;
      cmd = 1'b0;
      if (reset) begin
        last_wr_seen = 1'b0;
      end else begin
        pop = bus.rd_en;
        cmd = bus.cmd_en && !bus.cmd_full;
        if (bus.cmd_en && bus.cmd_full) check_val("cmd_en_while_full", 1, 0);
        if (last_wr_seen) begin
          check_val("busy_after_last_wr", mcb_busy, 0);
          last_wr_seen = 1'b0;
        end
        if (bus.buff_wr) begin
          if (exp_wr_q.size() == 0) begin
            check_val("unexpected_wr", 1, 0);
          end else begin
            e = exp_wr_q.pop_front();
            $display("wr addr=%0d data=%h", bus.buff_addr, bus.buff_data);
            check_val("wr_addr", bus.buff_addr, e.addr);
            check_val("wr_data", bus.buff_data, e.data);
            if (e.addr == 6'd63) begin
              check_val("busy_at_last_wr", mcb_busy, 1);
              last_wr_seen = 1'b1;
            end
          end
        end
        if (cmd) begin
          $display("cmd addr=%h bl=%0d instr=%0d", bus.cmd_byte_addr, bus.cmd_bl, bus.cmd_instr);
          if (exp_cmd_q.size() == 0) check_val("unexpected_cmd", 1, 0);
          else check_val("cmd_addr", bus.cmd_byte_addr, {6'b0, exp_cmd_q.pop_front()});
          check_val("cmd_instr", bus.cmd_instr, 3'b001);
          check_val("cmd_bl", bus.cmd_bl, 6'd63);
        end
        if (pop && rdq.size() == 0) check_val("rd_en_on_empty", 1, 0);
      end
      @(posedge clk);
      #2;
      if (reset) begin
        rdq.delete();
      end else begin
        if (pop && rdq.size() > 0) void'(rdq.pop_front());
        if (cmd) begin
          for (int i = 0; i < 64; i++) begin
            if (next_word < data_limit) rdq.push_back(32'(next_word));
            next_word++;
          end
        end
      end
      bus.rd_empty = (rdq.size() == 0) || stall;
      bus.rd_data  = (rdq.size() > 0) ? rdq[0] : 32'h0;
    end
  end

  task automatic start_line(input logic [19:0] a, input int lim);
    logic [23:0]  base;
    wr_t          e;
    int           w;
    base = {a, 4'b0000};
    for (int n = 0; n < 4; n++) exp_cmd_q.push_back(base + 24'(n * 256));
    for (int g = 0; g < 64; g++) begin
      e.addr = 6'(g);
      e.data = '0;
      for (int j = 0; j < 4; j++) begin
        w = 4 * g + j;
        e.data[32*j +: 32] = (w < lim) ? 32'(w) : 32'h0;
      end
      exp_wr_q.push_back(e);
    end
    next_word  = 0;
    data_limit = lim;
    mcb_raddr  = a;
    mcb_rd     = 1'b1;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int n;
    n = 0;
    while (mcb_busy !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (mcb_busy !== lvl) check_val(tag, mcb_busy, lvl);
  endtask

  task automatic check_line_done(input string tag);
    check_val({tag, "_cmds_left"}, 128'(exp_cmd_q.size()), 0);
    check_val({tag, "_wrs_left"}, 128'(exp_wr_q.size()), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, mcb_busy, 0);
    check_val({tag, "_cmd_en"}, bus.cmd_en, 0);
    check_val({tag, "_rd_en"}, bus.rd_en, 0);
    check_val({tag, "_buff_wr"}, bus.buff_wr, 0);
    check_val({tag, "_buff_addr"}, bus.buff_addr, 0);
    check_val({tag, "_buff_data"}, bus.buff_data, 0);
    check_val({tag, "_fetch_err"}, fetch_err, 0);
  endtask

  initial begin
    reset     = 1'b1;
    mcb_rd    = 1'b0;
    mcb_raddr = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Line 1: basic fetch, rd held 10 cycles.
    start_line(20'h0BFC0, 256);
    repeat (10) @(posedge clk);
    #1 mcb_rd = 1'b0;
    wait_busy(1'b1, 10, "l1_busy_rise");
    wait_busy(1'b0, 2000, "l1_busy_fall");
    check_line_done("l1");

    // Line 2: rd left high across the whole line must not retrigger.
    @(posedge clk); #1;
    start_line(20'h00010, 256);
    wait_busy(1'b1, 20, "l2_busy_rise");
    wait_busy(1'b0, 2000, "l2_busy_fall");
    repeat (20) @(negedge clk);
    check_val("l2_no_retrigger", mcb_busy, 0);
    check_val("l2_no_cmd", 128'(exp_cmd_q.size()), 0);
    @(posedge clk); #1 mcb_rd = 1'b0;
    check_line_done("l2");
    repeat (3) @(posedge clk);
    #1;

    // Line 3: command FIFO full for 50 cycles after the first command.
    start_line(20'h01230, 256);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.cmd_en && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_val("l3_first_cmd", bus.cmd_en, 1);
    end
    @(posedge clk); #1 bus.cmd_full = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      mcb_rd = 1'b0;
    end
    check_val("l3_cmds_held", 128'(exp_cmd_q.size()), 3);
    bus.cmd_full = 1'b0;
    wait_busy(1'b0, 2000, "l3_busy_fall");
    check_line_done("l3");
    @(posedge clk); #1;

    // Line 4: 24-bit address wrap.
    start_line(20'hFFFF0, 256);
    repeat (10) @(posedge clk);
    #1 mcb_rd = 1'b0;
    wait_busy(1'b0, 2000, "l4_busy_fall");
    check_line_done("l4");
    @(posedge clk); #1;

    // Line 5: random read-FIFO stalls, then reset mid-line.
    start_line(20'h00400, 256);
    for (int c = 0; c < 150; c++) begin
      @(posedge clk); #1;
      if (c == 10) mcb_rd = 1'b0;
      stall = ($urandom_range(0, 2) == 0);
    end
    check_val("l5_busy_mid", mcb_busy, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    stall = 1'b0;
    exp_cmd_q.delete();
    exp_wr_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Line 6: normal line after reset.
    start_line(20'h00800, 256);
    repeat (10) @(posedge clk);
    #1 mcb_rd = 1'b0;
    wait_busy(1'b1, 10, "l6_busy_rise");
    wait_busy(1'b0, 2000, "l6_busy_fall");
    check_line_done("l6");
    check_val("l6_fetch_err", fetch_err, 0);

`ifdef VFETCH_TIMEOUT_EN
    // Line 7: data stops after 100 words; remainder written as zero.
    @(posedge clk); #1;
    start_line(20'h02000, 100);
    repeat (10) @(posedge clk);
    #1 mcb_rd = 1'b0;
    wait_busy(1'b1, 10, "l7_busy_rise");
    wait_busy(1'b0, 3000, "l7_busy_fall");
    check_line_done("l7");
    check_val("l7_fetch_err", fetch_err, 1);
    repeat (5) @(negedge clk);
    check_val("l7_fetch_err_sticky", fetch_err, 1);
`endif

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
